layer_tile_sequencer: RTL and testbench
=======================================

Name: layer_tile_sequencer

Overview:
- Responder side of the per-layer start/done handshake driven by the network top-level sequencer. The top level presents `Layer` and the layer's GEMM dimensions `M`/`N`/`K`, then advances `Layer` when it sees `LAYER_done`.
- This block detects a new layer and latches its dimensions. It then walks the output tiles (n outer, m middle, k inner) in `CHUNK_M`/`CHUNK_N`/`CHUNK_K` steps and issues each tile to the MAC array over a valid/ready + done handshake.
- After the last tile completes it returns a one-cycle `LAYER_done` pulse.

Parameters:
- NUM_LAYERS, 6, number of valid layers; `Layer >= NUM_LAYERS` means network finished.
- MAX_M, 784, maximum M (output pixels).
- MAX_N, 32, maximum N (output channels).
- MAX_K, 150, maximum K (X1*X2*X3).
- CHUNK_M, 1, tile size along M.
- CHUNK_N, 1, tile size along N.
- CHUNK_K, 4, tile size along K.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- Layer  in  4  current layer index from top-level sequencer
- M  in  $clog2(MAX_M)+1  output pixels of current layer
- N  in  $clog2(MAX_N)+1  output channels of current layer
- K  in  $clog2(MAX_K)+1  reduction length of current layer
- LAYER_done  out  1  one-cycle pulse: all tiles of current layer complete
- busy  out  1  high from LATCH through DONE
- tile_valid  out  1  tile descriptor valid
- tile_ready  in  1  MAC array accepts descriptor
- tile_m0  out  $clog2(MAX_M)+1  tile base index along M
- tile_n0  out  $clog2(MAX_N)+1  tile base index along N
- tile_k0  out  $clog2(MAX_K)+1  tile base index along K
- tile_m_len  out  $clog2(CHUNK_M)+1  valid rows, `min(CHUNK_M, M-tile_m0)`
- tile_n_len  out  $clog2(CHUNK_N)+1  valid columns, `min(CHUNK_N, N-tile_n0)`
- tile_k_len  out  $clog2(CHUNK_K)+1  valid reduction elements, `min(CHUNK_K, K-tile_k0)`
- tile_first_k  out  1  `tile_k0 == 0` (clear accumulator)
- tile_last_k  out  1  `tile_k0 + tile_k_len == K` (write back result)
- tile_done  in  1  one-cycle pulse: MAC array finished accepted tile

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; tile counters 0; `done_layer_q` = 4'hF.
- States: IDLE, LATCH, ISSUE, WAIT, DONE.
- IDLE:
  - Go to LATCH when `Layer < NUM_LAYERS` and `Layer != done_layer_q`.
  - Otherwise stay. In particular, with `Layer >= NUM_LAYERS` the block stays idle forever.
- LATCH (1 cycle):
  - Register `M`, `N`, `K` and `Layer`; later input changes are ignored until the next IDLE.
  - Clear counters m0 = n0 = k0 = 0.
  - If any latched dimension is 0, go to DONE; else go to ISSUE.
- ISSUE:
  - `tile_valid = 1`. Descriptor is registered and stable while `tile_valid && !tile_ready`.
  - On `tile_valid && tile_ready`, go to WAIT with `tile_valid = 0` the next cycle.
- WAIT:
  - Only one tile is outstanding; `tile_done` is sampled only in WAIT and ignored in all other states.
  - On `tile_done`, advance counters:
    - `k0 += CHUNK_K`.
    - If `k0 + CHUNK_K >= K`: k0 = 0 and `m0 += CHUNK_M`.
    - If that also wraps: m0 = 0 and `n0 += CHUNK_N`.
    - If n also wraps: go to DONE; else go to ISSUE.
- DONE (1 cycle):
  - `LAYER_done = 1`, `done_layer_q <= latched Layer`, go to IDLE.
  - Latency from the final `tile_done` to `LAYER_done` is exactly 1 cycle.
- Top-level interaction: the top level updates `Layer` on the `LAYER_done` edge, so the next layer starts LATCH 2 cycles after DONE.
- Arithmetic:
  - All comparisons are unsigned.
  - Lengths are computed from latched dimensions.
  - Tile count = `ceil(M/CHUNK_M) * ceil(N/CHUNK_N) * ceil(K/CHUNK_K)`.
- `busy`: 1 in LATCH, ISSUE, WAIT and DONE; 0 in IDLE.
- Reset mid-layer: everything is abandoned and `done_layer_q` = F, so the layer restarts from tile 0 after reset is released.

Test Plan:
- Reset release with Layer=0, M=784, N=6, K=25, tile_ready=1 and tile_done 2 cycles after each accept:
  - 784*6*7 = 32928 tiles.
  - Every 7th tile has tile_k_len=1, tile_k0=24, tile_last_k=1.
  - Exactly one LAYER_done pulse.
- Layer=5, M=1, N=10, K=32:
  - 80 tiles, all tile_k_len=4.
  - tile_first_k at k0=0; tile_last_k at k0=28.
  - n0 sweeps 0..9.
  - LAYER_done 1 cycle after the 80th tile_done.
- tile_ready held low for 5 cycles mid-layer:
  - tile_valid stays high with the descriptor unchanged.
  - tile_done pulses during ISSUE are ignored (no counter advance).
- M=0 on Layer=2: LATCH → DONE, LAYER_done pulses with zero tiles issued.
- Full 6-layer run with a model top-level sequencer:
  - Each layer starts once; no pulse repeats.
  - At Layer=6 the block stays IDLE with busy=0.
- rst asserted while in WAIT on Layer 3:
  - Outputs are 0 immediately.
  - After release, Layer 3 restarts from m0=n0=k0=0.

Source files
------------

// File: rtl/layer_tile_sequencer_if.sv
// Tile descriptor handshake between the layer tile sequencer (master) and the MAC array (slave).
// Carries a valid/ready descriptor channel and a one-cycle completion pulse.
interface layer_tile_sequencer_if #(
   parameter int MAX_M   = 784,
   parameter int MAX_N   = 32,
   parameter int MAX_K   = 150,
   parameter int CHUNK_M = 1,
   parameter int CHUNK_N = 1,
   parameter int CHUNK_K = 4
);
   logic                       tile_valid;
   logic                       tile_ready;
   logic [$clog2(MAX_M):0]     tile_m0;
   logic [$clog2(MAX_N):0]     tile_n0;
   logic [$clog2(MAX_K):0]     tile_k0;
   logic [$clog2(CHUNK_M):0]   tile_m_len;
   logic [$clog2(CHUNK_N):0]   tile_n_len;
   logic [$clog2(CHUNK_K):0]   tile_k_len;
   logic                       tile_first_k;
   logic                       tile_last_k;
   logic                       tile_done;

   modport master (
      output tile_valid, tile_m0, tile_n0, tile_k0,
             tile_m_len, tile_n_len, tile_k_len, tile_first_k, tile_last_k,
      input  tile_ready, tile_done
   );

   modport slave (
      input  tile_valid, tile_m0, tile_n0, tile_k0,
             tile_m_len, tile_n_len, tile_k_len, tile_first_k, tile_last_k,
      output tile_ready, tile_done
   );
endinterface

// File: rtl/layer_tile_sequencer.sv
// Per-layer responder: latches a new layer's GEMM dimensions, walks its tiles (n outer, m middle,
// k inner) one at a time through the MAC array handshake, then pulses LAYER_done.
module layer_tile_sequencer #(
   parameter int NUM_LAYERS = 6,
   parameter int MAX_M      = 784,
   parameter int MAX_N      = 32,
   parameter int MAX_K      = 150,
   parameter int CHUNK_M    = 1,
   parameter int CHUNK_N    = 1,
   parameter int CHUNK_K    = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [3:0]             Layer,
   input  logic [$clog2(MAX_M):0] M,
   input  logic [$clog2(MAX_N):0] N,
   input  logic [$clog2(MAX_K):0] K,
   output logic                   LAYER_done,
   output logic                   busy,
   layer_tile_sequencer_if.master tile
);
   localparam int MW  = $clog2(MAX_M) + 1;
   localparam int NW  = $clog2(MAX_N) + 1;
   localparam int KW  = $clog2(MAX_K) + 1;
   localparam int MLW = $clog2(CHUNK_M) + 1;
   localparam int NLW = $clog2(CHUNK_N) + 1;
   localparam int KLW = $clog2(CHUNK_K) + 1;

   typedef enum logic [2:0] {S_IDLE, S_LATCH, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [3:0]      layer_q, layer_d;
   logic [3:0]      done_layer_q, done_layer_d;
   logic [MW-1:0]   m_q, m_d, m0_q, m0_d;
   logic [NW-1:0]   n_q, n_d, n0_q, n0_d;
   logic [KW-1:0]   k_q, k_d, k0_q, k0_d;

   logic [MW:0]     m_sum;
   logic [NW:0]     n_sum;
   logic [KW:0]     k_sum;
   logic [MW-1:0]   m_rem;
   logic [NW-1:0]   n_rem;
   logic [KW-1:0]   k_rem;
   logic [MLW-1:0]  m_len;
   logic [NLW-1:0]  n_len;
   logic [KLW-1:0]  k_len;

   assign m_sum = {1'b0, m0_q} + (MW+1)'(CHUNK_M);
   assign n_sum = {1'b0, n0_q} + (NW+1)'(CHUNK_N);
   assign k_sum = {1'b0, k0_q} + (KW+1)'(CHUNK_K);

   assign m_rem = m_q - m0_q;
   assign n_rem = n_q - n0_q;
   assign k_rem = k_q - k0_q;

   assign m_len = (m_rem >= MW'(CHUNK_M)) ? MLW'(CHUNK_M) : m_rem[MLW-1:0];
   assign n_len = (n_rem >= NW'(CHUNK_N)) ? NLW'(CHUNK_N) : n_rem[NLW-1:0];
   assign k_len = (k_rem >= KW'(CHUNK_K)) ? KLW'(CHUNK_K) : k_rem[KLW-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         layer_q      <= '0;
         done_layer_q <= 4'hF;
         m_q          <= '0;
         n_q          <= '0;
         k_q          <= '0;
         m0_q         <= '0;
         n0_q         <= '0;
         k0_q         <= '0;
      end else begin
         state_q      <= state_d;
         layer_q      <= layer_d;
         done_layer_q <= done_layer_d;
         m_q          <= m_d;
         n_q          <= n_d;
         k_q          <= k_d;
         m0_q         <= m0_d;
         n0_q         <= n0_d;
         k0_q         <= k0_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      layer_d      = layer_q;
      done_layer_d = done_layer_q;
      m_d          = m_q;
      n_d          = n_q;
      k_d          = k_q;
      m0_d         = m0_q;
      n0_d         = n0_q;
      k0_d         = k0_q;
      case (state_q)
         S_IDLE: begin
            if ((Layer < 4'(NUM_LAYERS)) && (Layer != done_layer_q)) begin
               state_d = S_LATCH;
            end
         end
         S_LATCH: begin
            layer_d = Layer;
            m_d     = M;
            n_d     = N;
            k_d     = K;
            m0_d    = '0;
            n0_d    = '0;
            k0_d    = '0;
            // Decide on the live inputs: they are the values being captured this edge.
            if ((M == '0) || (N == '0) || (K == '0)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (tile.tile_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (tile.tile_done) begin
               if (k_sum >= {1'b0, k_q}) begin
                  k0_d = '0;
                  if (m_sum >= {1'b0, m_q}) begin
                     m0_d = '0;
                     if (n_sum >= {1'b0, n_q}) begin
                        n0_d    = '0;
                        state_d = S_DONE;
                     end else begin
                        n0_d    = n_sum[NW-1:0];
                        state_d = S_ISSUE;
                     end
                  end else begin
                     m0_d    = m_sum[MW-1:0];
                     state_d = S_ISSUE;
                  end
               end else begin
                  k0_d    = k_sum[KW-1:0];
                  state_d = S_ISSUE;
               end
            end
         end
         S_DONE: begin
            done_layer_d = layer_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy            = (state_q != S_IDLE);
   assign LAYER_done      = (state_q == S_DONE);
   assign tile.tile_valid = (state_q == S_ISSUE);
   assign tile.tile_m0    = m0_q;
   assign tile.tile_n0    = n0_q;
   assign tile.tile_k0    = k0_q;
   assign tile.tile_m_len = m_len;
   assign tile.tile_n_len = n_len;
   assign tile.tile_k_len = k_len;
   // Flags qualified by valid so an idle or freshly reset block drives them low.
   assign tile.tile_first_k = tile.tile_valid && (k0_q == '0);
   assign tile.tile_last_k  = tile.tile_valid &&
                              (({1'b0, k0_q} + (KW+1)'(k_len)) == {1'b0, k_q});
endmodule

// File: tb/tb_layer_tile_sequencer.sv
// Directed bench for layer_tile_sequencer: table of layer runs with a MAC-array responder,
// plus hand sequences for reset during WAIT and the finished-network idle case.
module tb_layer_tile_sequencer;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  Layer;
   logic [10:0] M;
   logic [5:0]  N;
   logic [8:0]  K;
   logic        LAYER_done;
   logic        busy;

   layer_tile_sequencer_if tif ();

   layer_tile_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .Layer      (Layer),
      .M          (M),
      .N          (N),
      .K          (K),
      .LAYER_done (LAYER_done),
      .busy       (busy),
      .tile       (tif)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int layer;
      int m;
      int n;
      int k;
      int stall_at;
      int exp_tiles;
      int exp_last;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   function automatic logic [32:0] cur_desc();
      return {tif.tile_m0, tif.tile_n0, tif.tile_k0, tif.tile_m_len, tif.tile_n_len,
              tif.tile_k_len, tif.tile_first_k, tif.tile_last_k};
   endfunction

   function automatic logic [35:0] all_outputs();
      return {LAYER_done, busy, tif.tile_valid, cur_desc()};
   endfunction

   task automatic run_layer(input vec_t v, input string tag);
      int tiles = 0, last_cnt = 0, desc_err = 0, stall_err = 0, pulses = 0;
      int cyc = 0, post = 0, done_cnt = -1, stall_cnt = 0;
      int final_done_cyc = -1, pulse_cyc = -1, budget;
      int em = 0, en = 0, ek = 0, exp_kl, exp_ml, exp_nl;
      bit seen = 0;
      logic [32:0] snap = '0, exp_desc;
      string first_err = "";
      budget = 200 + v.exp_tiles * 12;
      @(negedge clk);
      Layer = 4'(v.layer);
      M = 11'(v.m);
      N = 6'(v.n);
      K = 9'(v.k);
      tif.tile_ready = 1'b1;
      tif.tile_done  = 1'b0;
      while (cyc < budget && !(seen && post >= 6)) begin
         @(negedge clk);
         cyc++;
         if (LAYER_done) begin
            pulses++;
            if (!seen) pulse_cyc = cyc;
            seen = 1;
         end
         if (seen) post++;
         if (tif.tile_valid && !busy) desc_err++;
         tif.tile_done = 1'b0;
         if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) begin
               tif.tile_done = 1'b1;
               done_cnt = -1;
               if (tiles == v.exp_tiles) final_done_cyc = cyc;
            end
         end
         if (v.stall_at >= 0 && tiles == v.stall_at && stall_cnt > 0 && stall_cnt < 5
             && !tif.tile_valid) stall_err++;
         if (tif.tile_valid) begin
            if (v.stall_at >= 0 && tiles == v.stall_at && stall_cnt < 5) begin
               if (stall_cnt == 0) snap = cur_desc();
               else if (cur_desc() != snap) stall_err++;
               stall_cnt++;
               tif.tile_ready = 1'b0;
               if (stall_cnt == 2) tif.tile_done = 1'b1;
            end else begin
               tif.tile_ready = 1'b1;
               exp_kl = (v.k - ek >= 4) ? 4 : v.k - ek;
               exp_ml = (v.m - em >= 1) ? 1 : v.m - em;
               exp_nl = (v.n - en >= 1) ? 1 : v.n - en;
               exp_desc = {11'(em), 6'(en), 9'(ek), 1'(exp_ml), 1'(exp_nl), 3'(exp_kl),
                           (ek == 0), (ek + exp_kl == v.k)};
               if (cur_desc() != exp_desc) begin
                  if (desc_err == 0)
                     first_err = $sformatf("tile%0d got=%h exp=%h", tiles, cur_desc(), exp_desc);
                  desc_err++;
               end
               if (tif.tile_last_k) last_cnt++;
               tiles++;
               done_cnt = 2;
               ek += 4;
               if (ek >= v.k) begin
                  ek = 0;
                  em++;
                  if (em >= v.m) begin
                     em = 0;
                     en++;
                  end
               end
            end
         end else begin
            tif.tile_ready = 1'b1;
         end
      end
      tif.tile_done = 1'b0;
      check({tag, " tiles"}, tiles, v.exp_tiles);
      check({tag, " desc_err ", first_err}, desc_err, 0);
      check({tag, " last_k_count"}, last_cnt, v.exp_last);
      check({tag, " layer_done_pulses"}, pulses, 1);
      if (v.exp_tiles > 0)
         check({tag, " done_latency"}, pulse_cyc - final_done_cyc, 1);
      if (v.stall_at >= 0) begin
         check({tag, " stall_err"}, stall_err, 0);
         check({tag, " stall_cycles"}, stall_cnt, 5);
      end
   endtask

   initial begin
      int acc, cyc, idle_busy, idle_valid;
      // layer, M, N, K, stall_at, tiles, last_k tiles (hand computed)
      vecs[0]  = '{0, 20, 6, 25,  -1, 840, 120};
      vecs[1]  = '{5,  1, 10, 32, -1, 80,  10};
      vecs[2]  = '{1,  3, 4, 10,   5, 36,  12};
      vecs[3]  = '{2,  0, 5, 5,   -1, 0,   0};
      vecs[4]  = '{3,  2, 2, 9,   -1, 12,  4};
      vecs[5]  = '{0,  4, 2, 8,   -1, 16,  8};
      vecs[6]  = '{1,  3, 3, 5,   -1, 18,  9};
      vecs[7]  = '{2,  2, 5, 4,   -1, 10,  10};
      vecs[8]  = '{3,  5, 1, 1,   -1, 5,   5};
      vecs[9]  = '{4,  1, 1, 150, -1, 38,  1};
      vecs[10] = '{5,  7, 2, 3,   -1, 14,  14};

      rst = 1'b1;
      Layer = 4'd0;
      M = 11'd20;
      N = 6'd6;
      K = 9'd25;
      tif.tile_ready = 1'b1;
      tif.tile_done  = 1'b0;
      repeat (3) @(negedge clk);
      check("reset outputs", all_outputs(), 0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) run_layer(vecs[i], $sformatf("vec%0d", i));

      // Reset while the second tile of layer 3 is outstanding.
      @(negedge clk);
      Layer = 4'd3;
      M = 11'd2;
      N = 6'd2;
      K = 9'd9;
      acc = 0;
      cyc = 0;
      while (cyc < 100) begin
         @(negedge clk);
         cyc++;
         tif.tile_done = busy && !tif.tile_valid && acc < 2;
         if (tif.tile_valid) acc++;
         else if (busy && acc == 2) break;
      end
      check("reach wait before reset", acc, 2);
      tif.tile_done = 1'b0;
      rst = 1'b1;
      #1;
      check("async reset outputs", all_outputs(), 0);
      @(negedge clk);
      rst = 1'b0;
      run_layer(vecs[4], "restart_l3");

      for (int i = 5; i < 11; i++) run_layer(vecs[i], $sformatf("full_l%0d", vecs[i].layer));

      @(negedge clk);
      Layer = 4'd6;
      idle_busy = 0;
      idle_valid = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy) idle_busy++;
         if (tif.tile_valid || LAYER_done) idle_valid++;
      end
      check("finished busy cycles", idle_busy, 0);
      check("finished activity cycles", idle_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
